// File: rtl/verify_array.sv
// Read-only scan of a 256-entry synchronous RAM: checks S[k] == k, counts mismatches,
// records the lowest mismatching index and accumulates a 16-bit byte checksum.
module verify_array (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [7:0]  address,
    input  logic [7:0]  q,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [8:0]  err_count,
    output logic [7:0]  first_err_addr,
    output logic [15:0] checksum
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t     state_r;
    logic [7:0] i_r;
    logic       mismatch_s;

    assign mismatch_s = (q != i_r);

    // Scan FSM with all outputs registered; address tracks i for the whole entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            i_r            <= 8'd0;
            address        <= 8'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 9'd0;
            first_err_addr <= 8'd0;
            checksum       <= 16'd0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r        <= ADDR;
                        i_r            <= 8'd0;
                        address        <= 8'd0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= 9'd0;
                        first_err_addr <= 8'd0;
                        checksum       <= 16'd0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ADDR: begin
                    state_r <= WAIT;
                end
                WAIT: begin
                    state_r <= CHECK;
                end
                CHECK: begin
                    checksum <= checksum + {8'd0, q};
                    if (mismatch_s) begin
                        err_count <= err_count + 9'd1;
                        if (err_count == 9'd0) begin
                            first_err_addr <= i_r;
                        end else begin
                            first_err_addr <= first_err_addr;
                        end
                    end else begin
                        err_count <= err_count;
                    end
                    // Last entry: i stays at 255 rather than wrapping
                    if (i_r != 8'd255) begin
                        state_r <= ADDR;
                        i_r     <= i_r + 8'd1;
                        address <= i_r + 8'd1;
                    end else begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_count == 9'd0) && !mismatch_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    i_r     <= 8'd0;
                    address <= 8'd0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    pass    <= 1'b0;
                end
            endcase
        end
    end

endmodule
